// File: rtl/station_pkg.sv
// station_pkg
// Shared definitions for the station system display path.
//   - station_e    : station codes shared with the material system
//   - disp_state_e : display FSM state encoding
//   - glyph_e      : display character codes, decoded by glyph_seg()
//   - SEG_*        : active-low segment patterns, bit order {g,f,e,d,c,b,a}
package station_pkg;

  typedef enum logic [1:0] {
    START  = 2'd0,
    HOT    = 2'd1,
    COLD   = 2'd2,
    FINISH = 2'd3
  } station_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } disp_state_e;

  // Codes 0..9 are the decimal digits so a BCD count maps straight onto them.
  typedef enum logic [4:0] {
    G_0 = 5'd0, G_1 = 5'd1, G_2 = 5'd2, G_3 = 5'd3, G_4 = 5'd4,
    G_5 = 5'd5, G_6 = 5'd6, G_7 = 5'd7, G_8 = 5'd8, G_9 = 5'd9,
    G_S = 5'd10, G_T = 5'd11, G_R = 5'd12, G_H = 5'd13, G_O = 5'd14,
    G_C = 5'd15, G_L = 5'd16, G_D = 5'd17, G_N = 5'd18, G_E = 5'd19,
    G_DASH = 5'd20, G_BLANK = 5'd21
  } glyph_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Active-low segment pattern for a glyph code; unused codes show a dash.
  function automatic logic [6:0] glyph_seg(input logic [4:0] code);
    logic [6:0] s;
    case (code)
      5'd0:  s = 7'h40;
      5'd1:  s = 7'h79;
      5'd2:  s = 7'h24;
      5'd3:  s = 7'h30;
      5'd4:  s = 7'h19;
      5'd5:  s = 7'h12;
      5'd6:  s = 7'h02;
      5'd7:  s = 7'h78;
      5'd8:  s = 7'h00;
      5'd9:  s = 7'h10;
      5'd10: s = 7'h12;  // S
      5'd11: s = 7'h07;  // t
      5'd12: s = 7'h2F;  // r
      5'd13: s = 7'h0B;  // h
      5'd14: s = 7'h23;  // o
      5'd15: s = 7'h46;  // C
      5'd16: s = 7'h47;  // L
      5'd17: s = 7'h21;  // d
      5'd18: s = 7'h2B;  // n
      5'd19: s = 7'h06;  // E
      5'd20: s = SEG_DASH;
      5'd21: s = SEG_BLANK;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/station_display_if.sv
// station_display_if
// Bundles the trigger/station inputs from the material system with the
// seven-segment outputs of the display.
//   correctStation : trigger level (display acts on rising edge)
//   station        : 2-bit station code
//   seg / an / dp  : active-low segments {g,f,e,d,c,b,a}, digit enables, dp
// Modports: master = material-system side, slave = display.
interface station_display_if;
  logic       correctStation;
  logic [1:0] station;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  modport master (
    output correctStation,
    output station,
    input  seg,
    input  an,
    input  dp
  );

  modport slave (
    input  correctStation,
    input  station,
    output seg,
    output an,
    output dp
  );
endinterface

// File: rtl/seg_scan_mux.sv
// seg_scan_mux
// Multiplexes four glyphs onto a common-anode 4-digit display.
//   clk    : clock
//   srst   : synchronous active-high reset
//   glyphs : four active-low segment patterns, index 0 = leftmost digit
//   seg    : registered active-low segments
//   an     : registered active-low digit enables, an[3] = leftmost
// Each digit stays enabled for REFRESH_CYCLES clocks.
module seg_scan_mux #(
  parameter int REFRESH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            srst,
  input  logic [3:0][6:0] glyphs,
  output logic [6:0]      seg,
  output logic [3:0]      an
);

  localparam int SCAN_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(REFRESH_CYCLES - 1);

  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]        digit_idx_q, digit_idx_d;
  logic [6:0]        seg_q, seg_d;
  logic [3:0]        an_q, an_d;
  logic [3:0]        an_dec;

  // digit_idx 0 is the leftmost digit, which is an[3].
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_an
      assign an_dec[gi] = (digit_idx_q != 2'(3 - gi));
    end
  endgenerate

  always_comb begin
    scan_cnt_d  = scan_cnt_q + SCAN_W'(1);
    digit_idx_d = digit_idx_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d  = '0;
      digit_idx_d = digit_idx_q + 2'd1;
    end
    // seg and an come from the same digit index and share one register stage.
    seg_d = glyphs[digit_idx_q];
    an_d  = an_dec;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      scan_cnt_q  <= '0;
      digit_idx_q <= 2'd0;
      seg_q       <= 7'h7F;
      an_q        <= 4'hF;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      digit_idx_q <= digit_idx_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: rtl/station_display.sv
// station_display
// Seven-segment receiver for the station system. Idle shows "St" + blank +
// count of correct-station events; each rising edge of correctStation shows
// the station word for HOLD_CYCLES clocks, then returns to the count.
//   CLK   : station-system clock
//   reset : synchronous active-high reset
//   bus   : station_display_if.slave (correctStation, station in;
//           seg, an, dp out)
module station_display
  import station_pkg::*;
#(
  parameter int REFRESH_CYCLES = 2,
  parameter int HOLD_CYCLES    = 3000
) (
  input  logic               CLK,
  input  logic               reset,
  station_display_if.slave   bus
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  logic              cs_q;
  logic              trig_edge;
  disp_state_e       state_q, state_d;
  station_e          station_q, station_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [3:0]        count_q, count_d;

  glyph_e            word_w [4];
  logic [3:0][6:0]   glyphs_w;
  logic [6:0]        seg_w;
  logic [3:0]        an_w;

  assign trig_edge = bus.correctStation & ~cs_q;

  always_comb begin
    state_d   = state_q;
    station_d = station_q;
    hold_d    = hold_q;
    count_d   = count_q;
    if (trig_edge) begin
      // Entry and retrigger behave the same, including an edge that lands
      // on the last hold cycle.
      state_d   = ST_SHOW;
      station_d = station_e'(bus.station);
      hold_d    = HOLD_LOAD;
      count_d   = (count_q == 4'd9) ? 4'd0 : count_q + 4'd1;
    end else if (state_q == ST_SHOW) begin
      if (hold_q == '0) begin
        state_d = ST_IDLE;
      end else begin
        hold_d = hold_q - HOLD_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      cs_q      <= 1'b0;
      state_q   <= ST_IDLE;
      station_q <= START;
      hold_q    <= '0;
      count_q   <= 4'd0;
    end else begin
      cs_q      <= bus.correctStation;
      state_q   <= state_d;
      station_q <= station_d;
      hold_q    <= hold_d;
      count_q   <= count_d;
    end
  end

  // The word is chosen from next-state values so the digit registered on the
  // trigger edge already carries the new word.
  always_comb begin
    word_w[0] = G_S;
    word_w[1] = G_T;
    word_w[2] = G_BLANK;
    word_w[3] = glyph_e'({1'b0, count_d});
    if (state_d == ST_SHOW) begin
      unique case (station_d)
        START: begin
          word_w[0] = G_S; word_w[1] = G_T; word_w[2] = G_R; word_w[3] = G_T;
        end
        HOT: begin
          word_w[0] = G_H; word_w[1] = G_O; word_w[2] = G_T; word_w[3] = G_BLANK;
        end
        COLD: begin
          word_w[0] = G_C; word_w[1] = G_O; word_w[2] = G_L; word_w[3] = G_D;
        end
        FINISH: begin
          word_w[0] = G_D; word_w[1] = G_O; word_w[2] = G_N; word_w[3] = G_E;
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_glyph
      assign glyphs_w[gi] = glyph_seg(word_w[gi]);
    end
  endgenerate

  seg_scan_mux #(
    .REFRESH_CYCLES(REFRESH_CYCLES)
  ) u_scan (
    .clk    (CLK),
    .srst   (reset),
    .glyphs (glyphs_w),
    .seg    (seg_w),
    .an     (an_w)
  );

  assign bus.seg = seg_w;
  assign bus.an  = an_w;
  assign bus.dp  = 1'b1;

endmodule
